dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, meaning number of 32-bit words in the storage array (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, meaning wait states inserted before each valid response (0..15).
REQ-003 Ports: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  requester presents a transaction.
REQ-007 req_ready  output  1  block can accept a transaction this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_be  input  4  store byte enables; bit i selects wdata[8i+7:8i].
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  requester takes the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  transaction faulted.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; exactly one transaction is outstanding at a time.
REQ-017 req_ready SHALL be 1 only in IDLE; a transaction is accepted on a rising edge where req_valid & req_ready.
REQ-018 On acceptance, req_write, req_addr, req_wdata, req_be SHALL be latched; inputs are don't-care afterwards.
REQ-019 Error condition: req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH; the accepting edge moves directly to RESP with rsp_err=1, rsp_rdata=0, and no array write.
REQ-020 Non-error, WAIT_CYCLES=0: the accepting edge moves directly to RESP and performs the access on that edge.
REQ-021 Non-error, WAIT_CYCLES=W>0: the accepting edge enters WAIT with counter=W; each edge in WAIT decrements it; the edge where counter==1 enters RESP and performs the access.
REQ-022 rsp_valid SHALL therefore rise exactly W edges after the accepting edge for non-error requests, and 0 edges after for error requests.
REQ-023 Store access: only lanes with req_be[i]=1 are written; req_be=0 is a legal no-op with rsp_err=0; rsp_rdata=0.
REQ-024 Load access: rsp_rdata is the full addressed word, ignoring req_be, registered on the access edge.
REQ-025 In RESP, rsp_valid=1 and rsp_rdata and rsp_err SHALL remain stable until an edge with rsp_ready=1; that edge returns to IDLE.
REQ-026 A new request SHALL NOT be accepted on the same edge that completes a response; the earliest acceptance is the following edge.
REQ-027 A store followed by a load to the same word SHALL return the merged stored data.
REQ-028 Outside RESP, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-029 Address index is req_addr[log2(DEPTH)+1:2]; upper bits only participate in the range check.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-031 Reset mid-transaction SHALL discard the latched request; a store not yet performed is never written.
REQ-032 Array contents are not cleared by reset and are retained across it.
REQ-033 The first acceptance after reset is possible on the first rising edge with rst_n=1.

Verification
REQ-034 WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF -> rsp_valid 2 edges after accept, rsp_err 0; then load 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-035 Byte lanes: store 0x11223344 be 0xF to 0x20, then store 0xAABBCCDD be 0x5 -> load 0x20 returns 0x11BB33DD.
REQ-036 Errors: load addr 0x13 -> rsp_err 1, rsp_rdata 0, rsp_valid the edge after accept; store to 0x100 with DEPTH=64 -> rsp_err 1 and word 0 unchanged.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rsp_rdata stable throughout, req_ready 0; raise rsp_ready -> IDLE next edge.
REQ-038 Reset in WAIT during a store of 0xCAFEF00D to 0x8 that previously held 0x01234567 -> outputs cleared immediately; subsequent load of 0x8 returns 0x01234567.
REQ-039 WAIT_CYCLES=0, back-to-back loads with rsp_ready held 1 -> one response every 2 cycles, each rsp_valid 1 edge after its accept.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store requester and the data memory
// responder. The requester drives the master side; the responder the slave side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder: word-addressed storage with byte
// enables, a programmable number of wait states before each good response,
// and immediate error responses for misaligned or out-of-range addresses.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  counter;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic          lat_write;
    logic [AW-1:0] lat_index;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;

    logic [31:0] mem [DEPTH];

    logic          req_err;
    logic          access_now;
    logic          acc_write;
    logic [AW-1:0] acc_index;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [31:0]   rd_word;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Decide whether the array is touched on the coming edge and with which
    // operands: live bus fields when there are no wait states, else the latch.
    always_comb begin
        req_err    = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[31:AW+2]);
        access_now = 1'b0;
        acc_write  = lat_write;
        acc_index  = lat_index;
        acc_wdata  = lat_wdata;
        acc_be     = lat_be;
        if (WAIT_CYCLES == 0) begin
            if (rst_n && state == IDLE && bus.req_valid && !req_err) begin
                access_now = 1'b1;
                acc_write  = bus.req_write;
                acc_index  = bus.req_addr[AW+1:2];
                acc_wdata  = bus.req_wdata;
                acc_be     = bus.req_be;
            end
        end else if (rst_n && state == WAIT && counter == 4'd1) begin
            access_now = 1'b1;
        end
        rd_word = mem[acc_index];
    end

    // Storage array: byte-lane writes only, never cleared so contents survive reset.
    always_ff @(posedge clk) begin
        if (access_now && acc_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            lat_write   <= 1'b0;
            lat_index   <= '0;
            lat_wdata   <= 32'd0;
            lat_be      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_write   <= bus.req_write;
                        lat_index   <= bus.req_addr[AW+1:2];
                        lat_wdata   <= bus.req_wdata;
                        lat_be      <= bus.req_be;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else if (WAIT_CYCLES == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= bus.req_write ? 32'd0 : rd_word;
                        end else begin
                            state   <= WAIT;
                            counter <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    counter <= counter - 4'd1;
                    if (counter == 4'd1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= lat_write ? 32'd0 : rd_word;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    counter     <= 4'd0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states and one with
// none, both checked every cycle against a transaction-timing memory model,
// with directed scenarios pinning literal results and random traffic after.
module tb_dmem_responder;
    localparam int DEPTH = 64;

    logic clk;
    logic rst_n;

    logic        req_valid [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_ready [2];

    logic        req_ready_o [2];
    logic        rsp_valid_o [2];
    logic        rsp_err_o   [2];
    logic [31:0] rsp_rdata_o [2];

    int tests_run;
    int tests_failed;

    dmem_responder_if bus_w2 ();
    dmem_responder_if bus_w0 ();

    assign bus_w2.req_valid = req_valid[0];
    assign bus_w2.req_write = req_write[0];
    assign bus_w2.req_addr  = req_addr[0];
    assign bus_w2.req_wdata = req_wdata[0];
    assign bus_w2.req_be    = req_be[0];
    assign bus_w2.rsp_ready = rsp_ready[0];
    assign req_ready_o[0]   = bus_w2.req_ready;
    assign rsp_valid_o[0]   = bus_w2.rsp_valid;
    assign rsp_err_o[0]     = bus_w2.rsp_err;
    assign rsp_rdata_o[0]   = bus_w2.rsp_rdata;

    assign bus_w0.req_valid = req_valid[1];
    assign bus_w0.req_write = req_write[1];
    assign bus_w0.req_addr  = req_addr[1];
    assign bus_w0.req_wdata = req_wdata[1];
    assign bus_w0.req_be    = req_be[1];
    assign bus_w0.rsp_ready = rsp_ready[1];
    assign req_ready_o[1]   = bus_w0.req_ready;
    assign rsp_valid_o[1]   = bus_w0.rsp_valid;
    assign rsp_err_o[1]     = bus_w0.rsp_err;
    assign rsp_rdata_o[1]   = bus_w0.rsp_rdata;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w2)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each accepted request becomes "response due at edge N";
    // the memory is a plain array with a per-byte known mask.
    int unsigned cyc;
    bit          m_pending  [2];
    int unsigned m_ready_at [2];
    bit          m_err      [2];
    bit          m_store    [2];
    int          m_index    [2];
    logic [31:0] m_wdata    [2];
    logic [3:0]  m_be       [2];
    logic [31:0] m_rdata    [2];
    logic [31:0] m_rmask    [2];
    logic [31:0] m_mem      [2][DEPTH];
    logic [3:0]  m_known    [2][DEPTH];

    function automatic int waitOf(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] laneMask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic commitStore(input int k);
        for (int i = 0; i < 4; i++) begin
            if (m_be[k][i]) m_mem[k][m_index[k]][8*i +: 8] = m_wdata[k][8*i +: 8];
        end
        m_known[k][m_index[k]] = m_known[k][m_index[k]] | m_be[k];
    endtask

    task automatic modelEdge(input int k, input int unsigned n);
        logic [31:0] addr;
        if (m_pending[k]) begin
            if (cyc >= m_ready_at[k]) begin
                if (rsp_ready[k]) m_pending[k] = 1'b0;
            end else if (n == m_ready_at[k] && m_store[k]) begin
                commitStore(k);
            end
        end else if (req_valid[k]) begin
            addr          = req_addr[k];
            m_pending[k]  = 1'b1;
            m_err[k]      = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
            m_store[k]    = req_write[k] && !m_err[k];
            m_index[k]    = m_err[k] ? 0 : int'(addr / 4);
            m_wdata[k]    = req_wdata[k];
            m_be[k]       = req_be[k];
            m_ready_at[k] = n + (m_err[k] ? 0 : waitOf(k));
            if (m_err[k] || req_write[k]) begin
                m_rdata[k] = 32'd0;
                m_rmask[k] = 32'hFFFF_FFFF;
            end else begin
                m_rdata[k] = m_mem[k][m_index[k]];
                m_rmask[k] = laneMask(m_known[k][m_index[k]]);
            end
            if (m_store[k] && m_ready_at[k] == n) commitStore(k);
        end
    endtask

    // Advance the model on every rising edge; reset drops any pending request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending[0] = 1'b0;
            m_pending[1] = 1'b0;
        end else begin
            modelEdge(0, cyc + 1);
            modelEdge(1, cyc + 1);
            cyc = cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp, input logic [31:0] mask);
        tests_run++;
        if ((act & mask) !== (exp & mask)) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (mask 0x%08h) at %0t",
                     name, act, exp, mask, $time);
        end
    endtask

    task automatic compareCycle(input int k);
        bit exp_valid;
        exp_valid = m_pending[k] && (cyc >= m_ready_at[k]);
        checkOutput($sformatf("req_ready[%0d]", k), 32'(req_ready_o[k]), 32'(!m_pending[k]), 32'h1);
        checkOutput($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid_o[k]), 32'(exp_valid), 32'h1);
        checkOutput($sformatf("rsp_err[%0d]", k), 32'(rsp_err_o[k]), 32'(exp_valid && m_err[k]), 32'h1);
        checkOutput($sformatf("rsp_rdata[%0d]", k), rsp_rdata_o[k],
                    exp_valid ? m_rdata[k] : 32'd0,
                    exp_valid ? m_rmask[k] : 32'hFFFF_FFFF);
    endtask

    // Compare both instances against the model shortly after every rising edge.
    always @(posedge clk) begin
        #1;
        compareCycle(0);
        compareCycle(1);
    end

    task automatic applyStimulus(input int k, input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int hold, input bit early,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        rdata = 32'd0;
        err   = 1'b0;
        lat   = -1;
        req_valid[k] = 1'b1;
        req_write[k] = write;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        guard = 0;
        while (!req_ready_o[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept timeout[%0d]: got req_ready 0, expected 1 within 50 cycles", k);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom);
        if (early) rsp_ready[k] = 1'b1;
        guard = 0;
        while (!rsp_valid_o[k] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL response timeout[%0d]: got rsp_valid 0, expected 1 within 40 cycles", k);
            rsp_ready[k] = 1'b0;
            return;
        end
        lat   = guard;
        rdata = rsp_rdata_o[k];
        err   = rsp_err_o[k];
        if (!early) begin
            repeat (hold) @(negedge clk);
            rsp_ready[k] = 1'b1;
        end
        @(negedge clk);
        rsp_ready[k] = 1'b0;
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)       return 32'($urandom_range(0, 15)) << 2;
        else if (r < 7)  return 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (r == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 8) return 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
        else             return $urandom;
    endfunction

    task automatic randomTraffic(input int k, input int count);
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic        wr;
        for (int i = 0; i < count; i++) begin
            wr = 1'($urandom_range(0, 1));
            applyStimulus(k, wr, randAddr(), $urandom, 4'($urandom), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), rd, er, lt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 2000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          count;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
            req_be[k]    = 4'd0;
            rsp_ready[k] = 1'b0;
            m_pending[k] = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[k][a]   = 32'd0;
                m_known[k][a] = 4'd0;
            end
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset req_ready", 32'(req_ready_o[k]), 32'd1, 32'h1);
            checkOutput("reset rsp_valid", 32'(rsp_valid_o[k]), 32'd0, 32'h1);
            checkOutput("reset rsp_err", 32'(rsp_err_o[k]), 32'd0, 32'h1);
            checkOutput("reset rsp_rdata", rsp_rdata_o[k], 32'd0, 32'hFFFF_FFFF);
        end
        rst_n = 1'b1;

        $display("[TB] store/load round trip, two wait states");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lt);
        checkOutput("store latency", 32'(lt), 32'd2, 32'hFFFF_FFFF);
        checkOutput("store err", 32'(er), 32'd0, 32'h1);
        checkOutput("store rdata", rd, 32'd0, 32'hFFFF_FFFF);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lt);
        checkOutput("load rdata", rd, 32'hDEADBEEF, 32'hFFFF_FFFF);
        checkOutput("load latency", 32'(lt), 32'd2, 32'hFFFF_FFFF);

        $display("[TB] byte-lane merge");
        applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, rd, er, lt);
        applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1, 1'b0, rd, er, lt);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lt);
        checkOutput("merged word", rd, 32'h11BB33DD, 32'hFFFF_FFFF);

        $display("[TB] error responses");
        applyStimulus(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0, rd, er, lt);
        checkOutput("misaligned err", 32'(er), 32'd1, 32'h1);
        checkOutput("misaligned rdata", rd, 32'd0, 32'hFFFF_FFFF);
        checkOutput("misaligned latency", 32'(lt), 32'd0, 32'hFFFF_FFFF);
        applyStimulus(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, 1'b0, rd, er, lt);
        applyStimulus(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, er, lt);
        checkOutput("range err", 32'(er), 32'd1, 32'h1);
        checkOutput("range latency", 32'(lt), 32'd0, 32'hFFFF_FFFF);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, er, lt);
        checkOutput("word0 untouched", rd, 32'h0BADF00D, 32'hFFFF_FFFF);

        $display("[TB] empty byte enable store");
        applyStimulus(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 1'b0, rd, er, lt);
        checkOutput("be0 err", 32'(er), 32'd0, 32'h1);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, er, lt);
        checkOutput("be0 word kept", rd, 32'h11BB33DD, 32'hFFFF_FFFF);

        $display("[TB] response backpressure");
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, rd, er, lt);
        checkOutput("backpressure rdata", rd, 32'hDEADBEEF, 32'hFFFF_FFFF);

        $display("[TB] reset during wait states");
        applyStimulus(0, 1'b1, 32'h8, 32'h01234567, 4'hF, 0, 1'b0, rd, er, lt);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h8;
        req_wdata[0] = 32'hCAFEF00D;
        req_be[0]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checkOutput("in wait req_ready", 32'(req_ready_o[0]), 32'd0, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset req_ready", 32'(req_ready_o[0]), 32'd1, 32'h1);
        checkOutput("async reset rsp_valid", 32'(rsp_valid_o[0]), 32'd0, 32'h1);
        checkOutput("async reset rsp_err", 32'(rsp_err_o[0]), 32'd0, 32'h1);
        checkOutput("async reset rsp_rdata", rsp_rdata_o[0], 32'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, er, lt);
        checkOutput("discarded store", rd, 32'h01234567, 32'hFFFF_FFFF);
        checkOutput("first accept latency", 32'(lt), 32'd2, 32'hFFFF_FFFF);

        $display("[TB] zero wait states, back-to-back loads");
        applyStimulus(1, 1'b1, 32'h20, 32'h5A5A0001, 4'hF, 0, 1'b0, rd, er, lt);
        checkOutput("w0 store latency", 32'(lt), 32'd0, 32'hFFFF_FFFF);
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h20;
        req_be[1]    = 4'h0;
        count = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b valid %0d", i), 32'(rsp_valid_o[1]), 32'(i % 2), 32'h1);
            if (rsp_valid_o[1]) begin
                count++;
                checkOutput("b2b rdata", rsp_rdata_o[1], 32'h5A5A0001, 32'hFFFF_FFFF);
            end
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        checkOutput("b2b response count", 32'(count), 32'd5, 32'hFFFF_FFFF);

        $display("[TB] random traffic");
        fork
            randomTraffic(0, 150);
            randomTraffic(1, 150);
        join

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
